rf_2r1w_scheduler: RTL
======================

# rf_2r1w_scheduler

Write-arbiter and drain sequencer for the 8-entry, 30-bit, 2-read/1-write shift register file used by the PIRDSP partial-result path. Two producers compete for the single shifting write port under round-robin arbitration. The block tracks occupancy and blocks writes when the file is full. On command, it replays the stored entries oldest-first as pairs through the two read ports, then logically empties the file.

## Interface
- RF_width, 30, data width of each entry
- RF_size, 8, number of entries (power of two, ≥2)
- RF_addr_size, $clog2(RF_size), read-address width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req0_valid / req1_valid  in  1  producer write request
- req0_data / req1_data  in  RF_width  producer write data
- req0_ready / req1_ready  out  1  grant; a write occurs when valid&&ready
- drain_start  in  1  single-cycle drain command
- drain_busy  out  1  high from the first drain cycle through the done cycle
- drain_done  out  1  one-cycle pulse at the end of a drain
- rf_write_data  out  RF_width  to the register file
- rf_write_enable  out  1  to the register file
- rf_read_addr_0 / rf_read_addr_1  out  RF_addr_size  to the register file
- rf_read_data_0 / rf_read_data_1  in  RF_width  combinational read data from the register file
- pair_valid  out  1  pair output strobe
- pair_valid_1  out  1  second lane of the pair holds data
- pair_data_0 / pair_data_1  out  RF_width  older / younger entry of the pair
- count  out  RF_addr_size+1  occupancy, 0..RF_size

## Operation
- Register-file semantics: each write shifts the file, and the newest entry is at index 0. With count=N, the oldest entry is at index N-1.
- States: FILL, ISSUE, FLUSH. Reset state is FILL.
- FILL:
  - ready is asserted only in FILL with count<RF_size.
  - If exactly one valid is present, that producer is granted.
  - If both are valid, the producer that was not granted most recently is granted. After reset, req0 has priority.
  - The last-grant pointer updates only on an actual write.
  - Only one ready is high per cycle, and it is combinational from valid, state, count and the pointer.
  - rf_write_enable = granted valid. rf_write_data = the granted producer's data. count increments by 1.
- drain_start in FILL:
  - The write in the same cycle, if any, still completes.
  - Next state is ISSUE, with rem loaded from the updated count.
  - drain_start outside FILL is ignored.
- ISSUE, per cycle with rem>0:
  - rf_read_addr_0 = rem-1; rf_read_addr_1 = rem-2 (0 if rem=1).
  - rf_read_data_0/1 are captured into the pair registers, with lane-1 valid = (rem≥2).
  - rem -= min(rem,2).
  - If the old rem≤2, go to FLUSH.
- ISSUE with rem=0: no capture; go to FLUSH.
- FLUSH: drain_done=1; count←0; next state is FILL.
- pair_valid is high in the cycle after each capture. pair_data and pair_valid_1 hold their value until the next capture.
- drain_busy = (state≠FILL).
- No writes are accepted in ISSUE or FLUSH, because both readys are 0.
- When idle, read addresses are 0.

## Timing
- Reset values: count=0, state FILL, pointer=req1, so req0 has priority.
  - All outputs are 0, except that the combinational readys follow their rule.
- Write latency: an entry is visible at index 0 one cycle after a valid&&ready handshake.
- Drain with N entries:
  - The drain occupies ceil(N/2) ISSUE cycles plus 1 FLUSH cycle (min 1+1 for N=0).
  - pair_valid fires ceil(N/2) times. The last pair_valid coincides with drain_done in FLUSH.
- N=0: 1 ISSUE cycle and 1 FLUSH cycle; drain_done with no pair_valid.
- Reset mid-drain: the block returns to FILL immediately; count=0, pair_valid=0, drain_done=0.
- Full: at count=RF_size, both readys stay low until a drain completes. The first write is accepted in the cycle after FLUSH.

## Test plan
- Reset, then both producers continuously valid with data 0x1000+i (req0) / 0x2000+i (req1) -> grants alternate req0, req1, req0, …; count goes 1..8; readys drop at count=8.
- Only req1 valid for 3 cycles, then both valid -> req1 is granted 3 times, then req0, then req1.
- Write 8 values 1..8 in order, then drain_start -> 4 pairs: (1,2), (3,4), (5,6), (7,8); all pair_valid_1=1; drain_done with the 4th pair; count=0; readys high the next cycle.
- Write 3 values 0xA, 0xB, 0xC, then drain -> pairs (0xA,0xB) then (0xC, lane1 invalid); drain_done on the 2nd pair.
- Drain at count=0 -> drain_busy high for 2 cycles, drain_done once, no pair_valid.
- Write 6 values, drain, assert rst_n=0 during the 2nd ISSUE cycle -> count=0, drain_busy=0, no further pair_valid; a subsequent write is accepted with count=1.

Source files
------------

// File: rtl/rf_2r1w_scheduler.sv
// Write arbiter and drain sequencer for a 2R1W shift register file.
// Round-robin write grants; drains entries oldest-first as pairs.
module rf_2r1w_scheduler #(
  parameter int RF_width     = 30,
  parameter int RF_size      = 8,
  parameter int RF_addr_size = $clog2(RF_size)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  input  logic [RF_width-1:0]     req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [RF_width-1:0]     req1_data,
  output logic                    req1_ready,
  input  logic                    drain_start,
  output logic                    drain_busy,
  output logic                    drain_done,
  output logic [RF_width-1:0]     rf_write_data,
  output logic                    rf_write_enable,
  output logic [RF_addr_size-1:0] rf_read_addr_0,
  output logic [RF_addr_size-1:0] rf_read_addr_1,
  input  logic [RF_width-1:0]     rf_read_data_0,
  input  logic [RF_width-1:0]     rf_read_data_1,
  output logic                    pair_valid,
  output logic                    pair_valid_1,
  output logic [RF_width-1:0]     pair_data_0,
  output logic [RF_width-1:0]     pair_data_1,
  output logic [RF_addr_size:0]   count
);

  localparam int CW = RF_addr_size + 1;
  localparam logic [CW-1:0] FULL = CW'(RF_size);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic                  last_q, last_d;
  logic                  pv_q, pv_d;
  logic                  pv1_q, pv1_d;
  logic [RF_width-1:0]   pd0_q, pd0_d;
  logic [RF_width-1:0]   pd1_q, pd1_d;
  logic                  can_wr;
  logic                  gnt0, gnt1;

  // last_q=1 means req1 won most recently, so req0 wins the next tie
  always_comb begin
    can_wr = (state_q == FILL) && (count_q < FULL);
    gnt0   = can_wr && req0_valid && (!req1_valid || last_q);
    gnt1   = can_wr && req1_valid && (!req0_valid || !last_q);
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rem_d          = rem_q;
    last_d         = last_q;
    pv_d           = 1'b0;
    pv1_d          = pv1_q;
    pd0_d          = pd0_q;
    pd1_d          = pd1_q;
    rf_read_addr_0 = '0;
    rf_read_addr_1 = '0;
    drain_done     = 1'b0;
    unique case (state_q)
      FILL: begin
        if (gnt0 || gnt1) begin
          count_d = count_q + ONE;
          last_d  = gnt1;
        end
        if (drain_start) begin
          state_d = ISSUE;
          rem_d   = count_d;
        end
      end
      ISSUE: begin
        if (rem_q != '0) begin
          rf_read_addr_0 = RF_addr_size'(rem_q - ONE);
          if (rem_q >= TWO) begin
            rf_read_addr_1 = RF_addr_size'(rem_q - TWO);
          end
          pv_d  = 1'b1;
          pv1_d = (rem_q >= TWO);
          pd0_d = rf_read_data_0;
          pd1_d = rf_read_data_1;
          rem_d = (rem_q >= TWO) ? rem_q - TWO : '0;
        end
        if (rem_q <= TWO) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        drain_done = 1'b1;
        count_d    = '0;
        state_d    = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      rem_q   <= '0;
      last_q  <= 1'b1;
      pv_q    <= 1'b0;
      pv1_q   <= 1'b0;
      pd0_q   <= '0;
      pd1_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      pv_q    <= pv_d;
      pv1_q   <= pv1_d;
      pd0_q   <= pd0_d;
      pd1_q   <= pd1_d;
    end
  end

  assign req0_ready      = gnt0;
  assign req1_ready      = gnt1;
  assign rf_write_enable = gnt0 || gnt1;
  assign rf_write_data   = gnt0 ? req0_data :
                           gnt1 ? req1_data : '0;
  assign drain_busy      = (state_q != FILL);
  assign pair_valid      = pv_q;
  assign pair_valid_1    = pv1_q;
  assign pair_data_0     = pd0_q;
  assign pair_data_1     = pd1_q;
  assign count           = count_q;

endmodule
